// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int LAT_DEFAULT        = 2;
    localparam int STARVE_MAX_DEFAULT = 3;
    localparam int STREAK_W           = 4;
    localparam int WAIT_CNT_W         = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } arb_state_e;

    // Picks the addressed 32-bit instruction word out of a doubleword.
    function automatic logic [31:0] word_select(input logic [63:0] dword, input logic hi);
        return hi ? dword[63:32] : dword[31:0];
    endfunction

endpackage

// File: rtl/mem_port_arbiter_grant.sv
// Fixed-priority data-over-fetch winner selection with a starvation streak counter.
module mem_grant_picker
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic sample_en,
    input  logic i_req,
    input  logic d_req,
    output logic grant_valid,
    output logic grant_fetch
);

    localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(STARVE_MAX);

    logic [STREAK_W-1:0] streak_q, streak_d;

    // The streak only grows while a fetch is actually being held off.
    always_comb begin
        grant_valid = sample_en && (i_req || d_req);
        grant_fetch = i_req && (!d_req || (streak_q == STREAK_LIMIT));
        streak_d    = streak_q;
        if (grant_valid) begin
            if (grant_fetch) begin
                streak_d = '0;
            end else if (i_req && (streak_q != STREAK_LIMIT)) begin
                streak_d = streak_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: one fetch and one data requester share a fixed-latency memory.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int LAT        = LAT_DEFAULT,
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        IReq,
    input  logic [63:0] IAddr,
    output logic        IAck,
    output logic [31:0] IData,
    input  logic        DReq,
    input  logic        DWrite,
    input  logic [63:0] DAddr,
    input  logic [63:0] DWData,
    output logic        DAck,
    output logic [63:0] DRData,
    output logic        MemEn,
    output logic        MemWrite,
    output logic [63:0] MemAddr,
    output logic [63:0] MemWData,
    input  logic [63:0] MemRData
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(LAT);

    arb_state_e            state_q, state_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic                  fetch_q, fetch_d;
    logic                  write_q, write_d;
    logic [63:0]           addr_q, addr_d;
    logic [63:0]           wdata_q, wdata_d;
    logic                  mem_en_q, mem_en_d;
    logic                  mem_write_q, mem_write_d;
    logic                  iack_q, iack_d;
    logic                  dack_q, dack_d;
    logic [31:0]           idata_q, idata_d;
    logic [63:0]           drdata_q, drdata_d;
    logic                  grant_valid, grant_fetch;
    logic                  unused_addr_bits;

    mem_grant_picker #(
        .STARVE_MAX (STARVE_MAX)
    ) u_picker (
        .clk         (CLK),
        .reset       (Reset),
        .sample_en   (state_q == ST_IDLE),
        .i_req       (IReq),
        .d_req       (DReq),
        .grant_valid (grant_valid),
        .grant_fetch (grant_fetch)
    );

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        fetch_d     = fetch_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mem_en_d    = 1'b0;
        mem_write_d = 1'b0;
        iack_d      = 1'b0;
        dack_d      = 1'b0;
        idata_d     = idata_q;
        drdata_d    = drdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    fetch_d     = grant_fetch;
                    write_d     = !grant_fetch && DWrite;
                    addr_d      = grant_fetch ? IAddr : DAddr;
                    wdata_d     = grant_fetch ? '0 : DWData;
                    mem_en_d    = 1'b1;
                    mem_write_d = write_d;
                    wait_cnt_d  = WAIT_LOAD;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            // Memory data is valid at the edge that ends the last wait cycle.
            ST_WAIT: begin
                if (wait_cnt_q == WAIT_CNT_W'(1)) begin
                    state_d = ST_RESP;
                    if (fetch_q) begin
                        iack_d  = 1'b1;
                        idata_d = word_select(MemRData, addr_q[2]);
                    end else begin
                        dack_d = 1'b1;
                        if (!write_q) begin
                            drdata_d = MemRData;
                        end
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= '0;
            fetch_q     <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_write_q <= 1'b0;
            iack_q      <= 1'b0;
            dack_q      <= 1'b0;
            idata_q     <= '0;
            drdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            fetch_q     <= fetch_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mem_en_q    <= mem_en_d;
            mem_write_q <= mem_write_d;
            iack_q      <= iack_d;
            dack_q      <= dack_d;
            idata_q     <= idata_d;
            drdata_q    <= drdata_d;
        end
    end

    // Byte offset within the doubleword never reaches the memory.
    assign unused_addr_bits = ^addr_q[1:0];

    assign MemEn    = mem_en_q;
    assign MemWrite = mem_write_q;
    assign MemAddr  = {addr_q[63:3], 3'b000};
    assign MemWData = wdata_q;
    assign IAck     = iack_q;
    assign DAck     = dack_q;
    assign IData    = idata_q;
    assign DRData   = drdata_q;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter LAT, default 2, SHALL be the fixed memory latency in cycles, legal range 1..7.
REQ-002 Parameter STARVE_MAX, default 3, SHALL be the maximum consecutive data grants while IReq is pending, legal range 1..15.
REQ-003 One clock; reset is synchronous and active-high; ports SHALL be named CLK and Reset.
REQ-004 CLK  in  1  rising-edge clock.
REQ-005 Reset  in  1  synchronous active-high reset.
REQ-006 IReq  in  1  fetch request; IAddr  in  64  fetch byte address; IAck  out  1  fetch done pulse; IData  out  32  fetched instruction.
REQ-007 DReq  in  1  data request; DWrite  in  1  1=store; DAddr  in  64  data byte address; DWData  in  64  store data; DAck  out  1  data done pulse; DRData  out  64  load data.
REQ-008 MemEn  out  1  memory access strobe; MemWrite  out  1  write strobe; MemAddr  out  64  doubleword address; MemWData  out  64  write data; MemRData  in  64  memory read data.

Function
REQ-009 States SHALL be IDLE, ISSUE, WAIT and RESP; all outputs SHALL be registered.
REQ-010 IDLE SHALL sample requests each edge; if any is high, the arbiter SHALL latch the winner's address, write flag and write data and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-011 Winner: DReq beats IReq, except fetch SHALL win when both are high and the streak count equals STARVE_MAX.
REQ-012 Streak count SHALL increment (saturating at STARVE_MAX) on a data grant with IReq high, SHALL clear on a fetch grant, and SHALL hold otherwise.
REQ-013 ISSUE SHALL last exactly 1 cycle with MemEn=1, MemAddr={addr[63:3],3'b000}, and MemWrite and MemWData from the latched request; MemEn and MemWrite SHALL be 0 in all other states.
REQ-014 WAIT SHALL last exactly LAT cycles, using a down-counter loaded with LAT on ISSUE entry.
REQ-015 At the edge ending WAIT, a fetch read SHALL capture IData = addr[2] ? MemRData[63:32] : MemRData[31:0], and a data read SHALL capture DRData = MemRData.
REQ-016 A data write SHALL leave DRData unchanged.
REQ-017 RESP SHALL last 1 cycle with IAck or DAck = 1 for the granted requester only, then go to IDLE.
REQ-018 The grant-sample edge to the ack cycle SHALL be LAT+2 cycles, and the issue rate SHALL be at most one access per LAT+3 cycles.
REQ-019 Requesters SHALL hold req, address and data stable until ack and SHALL drop req before the edge ending the cycle after ack; the arbiter SHALL ignore requests in ISSUE, WAIT and RESP.
REQ-020 IData and DRData SHALL hold their last captured values between acks.
REQ-021 IAck and DAck SHALL never be high in the same cycle.

Reset
REQ-022 Reset high at an edge SHALL force IDLE, clear the streak count, the WAIT counter and the latched request, and drive IAck, DAck, MemEn and MemWrite to 0 and MemAddr, MemWData, IData and DRData to all zeros.
REQ-023 Reset mid-transaction SHALL abandon the access with no ack; Reset has priority over every transition.

Structure
REQ-024 A shared package SHALL hold the state enum, the LAT and STARVE_MAX defaults, and the streak counter width (4 bits).
REQ-025 The winner selection and streak counter SHALL be one sub-module, mem_grant_picker; the FSM and datapath registers SHALL stay in the top module.

Verification
REQ-026 Single fetch, LAT=2: IReq=1, IAddr=0x14, memory returns 0x8A0A018C_AA0B014A at 0x10 -> MemEn at cycle 1, MemAddr=0x10, IAck at cycle 4, IData=0x8A0A018C.
REQ-027 Store then load: DWrite=1, DAddr=0x28, DWData=0x123456789ABCDEF0, then a load of 0x28 -> MemWrite pulse with that data, DAck twice, DRData=0x123456789ABCDEF0 after the second ack.
REQ-028 Simultaneous requests: IReq and DReq both held high for 10 accesses, STARVE_MAX=3 -> grant order D,D,D,I,D,D,D,I,D,D.
REQ-029 Reset asserted in the WAIT cycle of a data read -> no DAck, all outputs zero the next cycle, and a fresh IReq after reset is served normally.
REQ-030 LAT=1 and LAT=7 sweeps with back-to-back fetches -> ack exactly LAT+2 cycles after each grant sample, with no MemEn overlap.
